// File: rtl/pe_psum_drain.sv
// Partial-sum drain: accumulates PECOL-wide psum vectors over npass passes into a
// per-position buffer, then streams width-reduced results out. Optional saturation: PSUM_DRAIN_SAT_EN.
module pe_psum_drain #(
  parameter int DWD   = 16,
  parameter int PECOL = 4,
  parameter int ACCWD = 24,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [3:0]                 i_npass,
  input  logic [$clog2(DEPTH):0]     i_npos,
  input  logic                       i_psum_rdy,
  output logic                       o_psum_ack,
  input  logic [PECOL*DWD-1:0]       i_psum,
  output logic                       o_out_rdy,
  input  logic                       i_out_ack,
  output logic [PECOL*DWD-1:0]       o_out,
  output logic                       o_busy,
  output logic                       o_done
);

  // Handshake: a transfer happens on a rising edge where rdy and ack are both high;
  // o_psum_ack and o_out_rdy are decoded from state only, never from the partner's signal.

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           npos_q, npos_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [PW-1:0]           rdpos_q, rdpos_d;
  logic [3:0]              npass_q, npass_d;
  logic [3:0]              pass_q, pass_d;
  logic                    done_q, done_d;

  logic signed [ACCWD-1:0] buf_q [DEPTH][PECOL];
  logic signed [ACCWD-1:0] psum_ext [PECOL];

  logic                    psum_xfer;
  logic                    out_xfer;
  logic                    last_pos;
  logic                    last_pass;
  logic                    last_rd;
  logic [PW-1:0]           npos_clamp;
  logic [3:0]              npass_clamp;

  assign npos_clamp  = (i_npos == '0) ? PW'(1) :
                       (i_npos > PW'(DEPTH)) ? PW'(DEPTH) : i_npos;
  assign npass_clamp = (i_npass == 4'd0) ? 4'd1 : i_npass;

  assign psum_xfer = (state_q == S_ACCUM) && i_psum_rdy;
  assign out_xfer  = (state_q == S_DRAIN) && i_out_ack;
  assign last_pos  = (pos_q == npos_q - PW'(1));
  assign last_pass = (pass_q == npass_q - 4'd1);
  assign last_rd   = (rdpos_q == npos_q - PW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      npos_q  <= PW'(1);
      pos_q   <= '0;
      rdpos_q <= '0;
      npass_q <= 4'd1;
      pass_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      npos_q  <= npos_d;
      pos_q   <= pos_d;
      rdpos_q <= rdpos_d;
      npass_q <= npass_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    npos_d  = npos_q;
    pos_d   = pos_q;
    rdpos_d = rdpos_q;
    npass_d = npass_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          npos_d  = npos_clamp;
          npass_d = npass_clamp;
          pos_d   = '0;
          pass_d  = 4'd0;
          rdpos_d = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (psum_xfer) begin
          if (last_pos) begin
            pos_d  = '0;
            pass_d = pass_q + 4'd1;
            if (last_pass) begin
              state_d = S_DRAIN;
              rdpos_d = '0;
            end
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (out_xfer) begin
          if (last_rd) begin
            state_d = S_IDLE;
            rdpos_d = '0;
            done_d  = 1'b1;
          end else begin
            rdpos_d = rdpos_q + PW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < PECOL; c++) begin
      psum_ext[c] = ACCWD'($signed(i_psum[c*DWD +: DWD]));
    end
  end

  // The buffer is always written before it is read within a tile, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (psum_xfer) begin
      for (int c = 0; c < PECOL; c++) begin
        if (pass_q == 4'd0) buf_q[pos_q[AW-1:0]][c] <= psum_ext[c];
        else                buf_q[pos_q[AW-1:0]][c] <= buf_q[pos_q[AW-1:0]][c] + psum_ext[c];
      end
    end
  end

`ifdef PSUM_DRAIN_SAT_EN
  localparam logic signed [ACCWD-1:0] SAT_MAX = {{(ACCWD-DWD+1){1'b0}}, {(DWD-1){1'b1}}};
  localparam logic signed [ACCWD-1:0] SAT_MIN = {{(ACCWD-DWD+1){1'b1}}, {(DWD-1){1'b0}}};
  localparam logic [DWD-1:0]          OUT_MAX = {1'b0, {(DWD-1){1'b1}}};
  localparam logic [DWD-1:0]          OUT_MIN = {1'b1, {(DWD-1){1'b0}}};
  logic signed [ACCWD-1:0] rd_v;

  always_comb begin
    o_out = '0;
    rd_v  = '0;
    if (state_q == S_DRAIN) begin
      for (int c = 0; c < PECOL; c++) begin
        rd_v = buf_q[rdpos_q[AW-1:0]][c];
        if (rd_v > SAT_MAX)      o_out[c*DWD +: DWD] = OUT_MAX;
        else if (rd_v < SAT_MIN) o_out[c*DWD +: DWD] = OUT_MIN;
        else                     o_out[c*DWD +: DWD] = rd_v[DWD-1:0];
      end
    end
  end
`else
  always_comb begin
    o_out = '0;
    if (state_q == S_DRAIN) begin
      for (int c = 0; c < PECOL; c++) begin
        o_out[c*DWD +: DWD] = buf_q[rdpos_q[AW-1:0]][c][DWD-1:0];
      end
    end
  end
`endif

  assign o_psum_ack = (state_q == S_ACCUM);
  assign o_out_rdy  = (state_q == S_DRAIN);
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = done_q;

endmodule

// File: tb/tb_pe_psum_drain.sv
// Bench for pe_psum_drain: directed and random tiles, reference sums kept as plain
// integers and pushed to a scoreboard queue that a monitor drains on output transfers.
module tb_pe_psum_drain;

  localparam int DWD   = 16;
  localparam int PECOL = 4;
  localparam int ACCWD = 24;
  localparam int DEPTH = 16;
  localparam int W     = PECOL * DWD;

  logic          i_clk;
  logic          i_rst;
  logic          i_start;
  logic [3:0]    i_npass;
  logic [4:0]    i_npos;
  logic          i_psum_rdy;
  logic          o_psum_ack;
  logic [W-1:0]  i_psum;
  logic          o_out_rdy;
  logic          i_out_ack;
  logic [W-1:0]  o_out;
  logic          o_busy;
  logic          o_done;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            ack_mode = 0;   // 0: ack held high, 1: random ack, 2: ack held low
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  psum_src[$];

  pe_psum_drain #(.DWD(DWD), .PECOL(PECOL), .ACCWD(ACCWD), .DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_npass    (i_npass),
    .i_npos     (i_npos),
    .i_psum_rdy (i_psum_rdy),
    .o_psum_ack (o_psum_ack),
    .i_psum     (i_psum),
    .o_out_rdy  (o_out_rdy),
    .i_out_ack  (i_out_ack),
    .o_out      (o_out),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  // Clock and reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Reference: total of all passes as an integer, wrapped to ACCWD, then reduced.
  function automatic logic [W-1:0] model_pos(input int ne, input int pe, input int p);
    logic [W-1:0] r;
    logic [W-1:0] v;
    longint s, w;
    longint lmax, lmin;
    r    = '0;
    lmax = (longint'(1) <<< (DWD - 1)) - 1;
    lmin = -(longint'(1) <<< (DWD - 1));
    for (int c = 0; c < PECOL; c++) begin
      s = 0;
      for (int k = 0; k < ne; k++) begin
        v = psum_src[k*pe + p];
        s += longint'($signed(v[c*DWD +: DWD]));
      end
      w = s & ((longint'(1) <<< ACCWD) - 1);
      if (w >= (longint'(1) <<< (ACCWD - 1))) w -= (longint'(1) <<< ACCWD);
`ifdef PSUM_DRAIN_SAT_EN
      if (w > lmax)      w = lmax;
      else if (w < lmin) w = lmin;
`else
      if (w > lmax || w < lmin) w = w;
`endif
      r[c*DWD +: DWD] = w[DWD-1:0];
    end
    return r;
  endfunction

  // Downstream ack driver
  initial begin
    i_out_ack = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (ack_mode)
        0:       i_out_ack = 1'b1;
        1:       i_out_ack = 1'($urandom_range(0, 1));
        default: i_out_ack = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] hold_val;
    logic         hold_valid;
    hold_valid = 1'b0;
    hold_val   = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        hold_valid = 1'b0;
      end else begin
        if (o_out_rdy) begin
          if (hold_valid) check("out_stable", o_out, hold_val);
          if (i_out_ack) begin
            hold_valid = 1'b0;
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_out: got %h expected none", o_out);
            end else begin
              check("out_data", o_out, exp_q.pop_front());
            end
          end else begin
            hold_valid = 1'b1;
            hold_val   = o_out;
          end
        end else begin
          hold_valid = 1'b0;
        end
        if (o_done && exp_q.size() != 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL early_done: got %0d pending expected 0", exp_q.size());
        end
      end
    end
  end

  // Driver tasks
  task automatic start_tile(input int npass, input int npos);
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge i_clk);
      if (!o_busy) begin idle = 1'b1; break; end
    end
    check("idle_before_start", 64'(idle), 64'd1);
    i_npass = 4'(npass);
    i_npos  = 5'(npos);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_npass = 4'($urandom_range(0, 15));
    i_npos  = 5'($urandom_range(0, 31));
    check("start_busy", 64'(o_busy), 64'd1);
    check("start_psum_ack", 64'(o_psum_ack), 64'd1);
  endtask

  task automatic send_psum(input logic [W-1:0] v);
    bit ok;
    ok         = 1'b0;
    i_psum     = v;
    i_psum_rdy = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge i_clk);
      if (o_psum_ack) begin
        @(posedge i_clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    i_psum_rdy = 1'b0;
    i_psum     = W'({$urandom, $urandom});
    if (!ok) check("psum_ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge i_clk);
      if (o_done) begin got = 1'b1; break; end
    end
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      check("done_busy", 64'(o_busy), 64'd0);
      check("done_all_out", 64'(exp_q.size()), 64'd0);
      @(negedge i_clk);
      check("done_one_cycle", 64'(o_done), 64'd0);
    end
    exp_q.delete();
  endtask

  task automatic run_tile(input int npass, input int npos, input int gap_max,
                          input int ack_m, input bit stall);
    int ne, pe;
    ne = (npass == 0) ? 1 : npass;
    pe = (npos == 0) ? 1 : ((npos > DEPTH) ? DEPTH : npos);
    for (int p = 0; p < pe; p++) exp_q.push_back(model_pos(ne, pe, p));
    ack_mode = stall ? 2 : ack_m;
    start_tile(npass, npos);
    for (int k = 0; k < ne * pe; k++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge i_clk);
          #1;
        end
      end
      send_psum(psum_src[k]);
    end
    check("out_rdy_after_last_psum", 64'(o_out_rdy), 64'd1);
    if (stall) begin
      for (int s = 0; s < 5; s++) begin
        @(negedge i_clk);
        check("stall_out_rdy", 64'(o_out_rdy), 64'd1);
        check("stall_no_done", 64'(o_done), 64'd0);
      end
      ack_mode = 0;
    end
    wait_done();
    psum_src.delete();
    ack_mode = 0;
  endtask

  initial begin
    int np, nq, ne, pe;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_npass    = 4'd0;
    i_npos     = 5'd0;
    i_psum_rdy = 1'b0;
    i_psum     = '0;
    #3;
    check("rst_psum_ack", 64'(o_psum_ack), 64'd0);
    check("rst_out_rdy", 64'(o_out_rdy), 64'd0);
    check("rst_out", 64'(o_out), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Two positions, one pass
    psum_src.push_back(mk(1, 2, 3, 4));
    psum_src.push_back(mk(5, 6, 7, 8));
    run_tile(1, 2, 0, 0, 1'b0);

    // Three passes, one position
    repeat (3) psum_src.push_back(mk(100, -7, 0, 1));
    run_tile(3, 1, 0, 0, 1'b0);

    // Overflow of the output width: wrap or saturate
    repeat (2) psum_src.push_back(mk(30000, -30000, 32767, -32768));
    run_tile(2, 1, 0, 0, 1'b0);

    // Gapped input and a stalled drain
    psum_src.push_back(mk(11, -12, 13, -14));
    psum_src.push_back(mk(21, -22, 23, -24));
    psum_src.push_back(mk(31, -32, 33, -34));
    run_tile(1, 3, 3, 0, 1'b1);

    // Reset in the middle of accumulation
    ack_mode = 0;
    start_tile(1, 4);
    send_psum(mk(1, 1, 1, 1));
    send_psum(mk(2, 2, 2, 2));
    #2;
    i_rst = 1'b1;
    #1;
    check("midrst_psum_ack", 64'(o_psum_ack), 64'd0);
    check("midrst_out_rdy", 64'(o_out_rdy), 64'd0);
    check("midrst_out", 64'(o_out), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_done", 64'(o_done), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      check("post_rst_idle", 64'(o_busy), 64'd0);
      check("post_rst_no_out", 64'(o_out_rdy), 64'd0);
    end
    psum_src.push_back(mk(9, 9, 9, 9));
    run_tile(1, 1, 0, 0, 1'b0);

    // Zero counts treated as one; oversize npos clamped to DEPTH
    psum_src.push_back(mk(-5, 7, 1234, -32768));
    run_tile(0, 0, 0, 0, 1'b0);
    for (int k = 0; k < DEPTH; k++) psum_src.push_back(W'({$urandom, $urandom}));
    run_tile(1, 31, 0, 1, 1'b0);

    // Random tiles with random gaps and backpressure
    for (int t = 0; t < 8; t++) begin
      np = $urandom_range(0, 4);
      nq = $urandom_range(0, 20);
      ne = (np == 0) ? 1 : np;
      pe = (nq == 0) ? 1 : ((nq > DEPTH) ? DEPTH : nq);
      for (int k = 0; k < ne * pe; k++) psum_src.push_back(W'({$urandom, $urandom}));
      run_tile(np, nq, 2, 1, 1'b0);
    end

    repeat (3) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_psum_drain.md
# pe_psum_drain

Receiving end of the PE partial-sum output channel. Accepts PECOL-wide psum vectors from a PE over the rdy/ack handshake and accumulates them across a programmable number of passes into a local per-position buffer. After the final pass it streams the accumulated, width-reduced results to the global buffer over a second rdy/ack channel. One instance sits behind each PE column group.

## Interface
Parameters:
- DWD, 16: psum and output element width, signed two's complement.
- PECOL, 4: lanes per psum vector.
- ACCWD, 24: accumulator width, signed; must satisfy ACCWD ≥ DWD.
- DEPTH, 16: maximum number of output positions per tile.

Ports:
- i_clk, in, 1: clock; all state changes on its rising edge.
- i_rst, in, 1: asynchronous, active-high reset.
- i_start, in, 1: starts a tile; sampled only in IDLE.
- i_npass, in, 4: passes per tile; 0 is treated as 1.
- i_npos, in, $clog2(DEPTH)+1: positions per tile; 0 is treated as 1, values above DEPTH are clamped to DEPTH.
- i_psum_rdy, in, 1: PE has a valid psum vector.
- o_psum_ack, out, 1: drain accepts the psum vector.
- i_psum, in, PECOL×DWD: psum vector, signed.
- o_out_rdy, out, 1: output vector valid.
- i_out_ack, in, 1: downstream accepts the output vector.
- o_out, out, PECOL×DWD: result vector.
- o_busy, out, 1: high whenever the state is not IDLE.
- o_done, out, 1: one-cycle pulse after the last output transfer.

## Operation
- Transfer rule: a transfer occurs on a rising edge where rdy and ack are both high. rdy must not depend combinationally on ack.
- States:
  - IDLE: on i_start, latch the clamped npass and npos, clear pos and pass, go to ACCUM.
  - ACCUM: o_psum_ack = 1. On each psum transfer:
    - buf[pos][c] is loaded with sext(i_psum[c]) when pass == 0, otherwise buf[pos][c] += sext(i_psum[c]).
    - pos increments. At pos == npos−1, pos wraps to 0 and pass increments.
    - On the transfer where pos == npos−1 and pass == npass−1, go to DRAIN with rdpos = 0.
  - DRAIN: o_out_rdy = 1 and o_out[c] = reduce(buf[rdpos][c]). On each output transfer rdpos increments. On the transfer where rdpos == npos−1, go to IDLE and pulse o_done.
- Accumulator arithmetic wraps modulo 2^ACCWD.
- The buffer is never read before being written within a tile, so it has no reset.
- i_start outside IDLE is ignored.
- i_npass and i_npos are ignored after being latched.

## Timing
- Reset values: o_psum_ack = 0, o_out_rdy = 0, o_out = 0, o_busy = 0, o_done = 0. State = IDLE; pos, pass and rdpos = 0.
- Reset asserted mid-operation aborts the tile immediately, with no output transfers and no o_done.
- Cycle after i_start: ACCUM, o_psum_ack = 1.
- Psum throughput: one vector per cycle.
- Cycle after the last psum transfer: o_out_rdy = 1, with o_out valid for rdpos 0.
- o_out is stable while o_out_rdy is high and no transfer occurs.
- Output throughput: one vector per cycle under continuous i_out_ack.
- o_done is high in the cycle after the last output transfer, together with o_busy = 0.
- The earliest the next i_start is accepted is the same cycle o_done is high.
- ACCUM and DRAIN never overlap, so a tile of npos positions and npass passes takes at least npos·npass + npos + 1 cycles from i_start.

## Configuration
- PSUM_DRAIN_SAT_EN defined: reduce() saturates the ACCWD value to [−2^(DWD−1), 2^(DWD−1)−1].
- PSUM_DRAIN_SAT_EN undefined: reduce() takes the low DWD bits (wrap).

## Test plan
Defaults: DWD = 16, PECOL = 4, ACCWD = 24, DEPTH = 16.
- npass=1, npos=2; psum {1,2,3,4} then {5,6,7,8}; i_out_ack held 1 → outputs {1,2,3,4} then {5,6,7,8}, then o_done for one cycle.
- npass=3, npos=1; psum {100,−7,0,1} three times → single output {300,−21,0,3}.
- npass=2, npos=1; psum {30000,−30000,32767,−32768} twice →
  - with PSUM_DRAIN_SAT_EN: {32767,−32768,32767,−32768};
  - without: {−5536,5536,−2,0}.
- npass=1, npos=3; drive i_psum_rdy with gaps and hold i_out_ack low 5 cycles during DRAIN → no lost or duplicated vectors; o_out and o_out_rdy held during the stall; o_done only after the 3rd output transfer.
- i_rst pulsed after 2 of 4 psum transfers → all outputs 0 and state IDLE. A fresh tile (npass=1, npos=1, psum {9,9,9,9}) then returns {9,9,9,9}.
- npos=0 and npass=0, then npos=31 → the first tile takes 1 psum and gives 1 output; the second takes 16 psums and gives 16 outputs.
